// File: rtl/st7735_rx.sv
// st7735_rx: panel-side decoder for the ST7735 4-wire SPI write stream.
// Oversamples the SPI pins on SYSTEM_CLK and rebuilds command/data bytes.
// Define ST7735_RX_PIXEL_EN to also build the CASET/RASET/RAMWR tracker
// that turns RAMWR data into addressed RGB565 pixel writes; without it only
// the byte path exists and the pixel outputs are tied low.
module st7735_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 128,
  parameter int HEIGHT      = 160
) (
  input  logic        SYSTEM_CLK,
  input  logic        RESET_N,
  input  logic        CS,
  input  logic        MOSI,
  input  logic        DC,
  input  logic        LCD_CLK,
  input  logic        LCD_RESET,
  output logic        BYTE_VALID,
  output logic [7:0]  BYTE,
  output logic        BYTE_IS_DATA,
  output logic        PIX_VALID,
  output logic [7:0]  PIX_X,
  output logic [7:0]  PIX_Y,
  output logic [15:0] PIX_DATA
);

  // Coordinates are 8 bits wide, so the panel must fit in 256x256.
  if (WIDTH < 1 || WIDTH > 256 || HEIGHT < 1 || HEIGHT > 256 || SYNC_STAGES < 2) begin : g_bad_params
    $error("st7735_rx: unsupported parameter set");
  end

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] dc_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] lrst_sync;

  logic       cs_q;
  logic       mosi_q;
  logic       dc_q;
  logic       sclk_q;
  logic       sclk_qq;
  logic       lrst_q;

  logic       sclk_rise;
  logic       byte_done;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic [7:0] new_byte;

  // Bring the asynchronous SPI-side pins into the SYSTEM_CLK domain.
  always_ff @(posedge SYSTEM_CLK) begin
    if (!RESET_N) begin
      cs_sync   <= '1;
      mosi_sync <= '0;
      dc_sync   <= '0;
      sclk_sync <= '0;
      lrst_sync <= '1;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], DC};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], LCD_CLK};
      lrst_sync <= {lrst_sync[SYNC_STAGES-2:0], LCD_RESET};
    end
  end

  // One aligned stage after the synchronizers so the clock edge detector
  // and the data it qualifies always come from the same sample.
  always_ff @(posedge SYSTEM_CLK) begin
    if (!RESET_N) begin
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      dc_q    <= 1'b0;
      sclk_q  <= 1'b0;
      sclk_qq <= 1'b0;
      lrst_q  <= 1'b1;
    end else begin
      cs_q    <= cs_sync[SYNC_STAGES-1];
      mosi_q  <= mosi_sync[SYNC_STAGES-1];
      dc_q    <= dc_sync[SYNC_STAGES-1];
      sclk_q  <= sclk_sync[SYNC_STAGES-1];
      sclk_qq <= sclk_q;
      lrst_q  <= lrst_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_q & ~sclk_qq;
  assign new_byte  = {shift_reg[6:0], mosi_q};
  assign byte_done = lrst_q & ~cs_q & sclk_rise & (bit_cnt == 3'd7);

  // Shift MOSI in MSB first and publish each completed byte with its DC bit.
  always_ff @(posedge SYSTEM_CLK) begin
    if (!RESET_N) begin
      bit_cnt      <= 3'd0;
      shift_reg    <= 8'h00;
      BYTE_VALID   <= 1'b0;
      BYTE         <= 8'h00;
      BYTE_IS_DATA <= 1'b0;
    end else if (!lrst_q) begin
      bit_cnt    <= 3'd0;
      shift_reg  <= 8'h00;
      BYTE_VALID <= 1'b0;
    end else begin
      BYTE_VALID <= 1'b0;
      if (cs_q) begin
        bit_cnt <= 3'd0;
      end else if (sclk_rise) begin
        shift_reg <= new_byte;
        bit_cnt   <= bit_cnt + 3'd1;
        if (byte_done) begin
          BYTE         <= new_byte;
          BYTE_IS_DATA <= dc_q;
          BYTE_VALID   <= 1'b1;
        end
      end
    end
  end

`ifdef ST7735_RX_PIXEL_EN

  typedef enum logic [1:0] {
    IDLE,
    CASET,
    RASET,
    RAMWR
  } dec_state_t;

  localparam logic [7:0] XE_RST = 8'(WIDTH - 1);
  localparam logic [7:0] YE_RST = 8'(HEIGHT - 1);

  dec_state_t state;
  dec_state_t state_next;

  logic       cmd_byte;
  logic       data_byte;
  logic       enter_ramwr;
  logic       win_wr;
  logic       hi_wr;
  logic       pix_fire;

  logic [2:0] param_idx;
  logic [7:0] xs;
  logic [7:0] xe;
  logic [7:0] ys;
  logic [7:0] ye;
  logic [7:0] cur_x;
  logic [7:0] cur_y;
  logic       half;
  logic [7:0] hi_byte;

  assign cmd_byte  = byte_done & ~dc_q;
  assign data_byte = byte_done & dc_q;

  // Command decoder state register; the panel reset pin also returns it to IDLE.
  always_ff @(posedge SYSTEM_CLK) begin
    if (!RESET_N || !lrst_q) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Every command byte selects a new state; data bytes never change it.
  always_comb begin
    state_next = state;
    if (cmd_byte) begin
      case (new_byte)
        8'h2A:   state_next = CASET;
        8'h2B:   state_next = RASET;
        8'h2C:   state_next = RAMWR;
        default: state_next = IDLE;
      endcase
    end
  end

  // Decode which datapath action the byte completing this cycle triggers.
  always_comb begin
    enter_ramwr = 1'b0;
    win_wr      = 1'b0;
    hi_wr       = 1'b0;
    pix_fire    = 1'b0;
    if (cmd_byte && new_byte == 8'h2C) begin
      enter_ramwr = 1'b1;
    end
    if (data_byte && (state == CASET || state == RASET) && !param_idx[2]) begin
      win_wr = 1'b1;
    end
    if (data_byte && state == RAMWR) begin
      hi_wr    = ~half;
      pix_fire = half;
    end
  end

  // Window registers, write cursor and pixel assembly.
  always_ff @(posedge SYSTEM_CLK) begin
    if (!RESET_N || !lrst_q) begin
      param_idx <= 3'd0;
      xs        <= 8'h00;
      xe        <= XE_RST;
      ys        <= 8'h00;
      ye        <= YE_RST;
      cur_x     <= 8'h00;
      cur_y     <= 8'h00;
      half      <= 1'b0;
      hi_byte   <= 8'h00;
      PIX_VALID <= 1'b0;
      PIX_X     <= 8'h00;
      PIX_Y     <= 8'h00;
      PIX_DATA  <= 16'h0000;
    end else begin
      PIX_VALID <= 1'b0;
      if (cmd_byte) begin
        param_idx <= 3'd0;
        half      <= 1'b0;
      end
      if (enter_ramwr) begin
        cur_x <= xs;
        cur_y <= ys;
      end
      if (win_wr) begin
        param_idx <= param_idx + 3'd1;
        if (param_idx[1:0] == 2'd1) begin
          if (state == CASET) xs <= new_byte;
          else                ys <= new_byte;
        end
        if (param_idx[1:0] == 2'd3) begin
          if (state == CASET) xe <= new_byte;
          else                ye <= new_byte;
        end
      end
      if (hi_wr) begin
        hi_byte <= new_byte;
        half    <= 1'b1;
      end
      if (pix_fire) begin
        half      <= 1'b0;
        PIX_VALID <= 1'b1;
        PIX_DATA  <= {hi_byte, new_byte};
        PIX_X     <= cur_x;
        PIX_Y     <= cur_y;
        if (cur_x == xe) begin
          cur_x <= xs;
          cur_y <= (cur_y == ye) ? ys : cur_y + 8'd1;
        end else begin
          cur_x <= cur_x + 8'd1;
        end
      end
    end
  end

`else

  assign PIX_VALID = 1'b0;
  assign PIX_X     = 8'h00;
  assign PIX_Y     = 8'h00;
  assign PIX_DATA  = 16'h0000;

`endif

endmodule

// File: tb/tb_st7735_rx.sv
// tb_st7735_rx: drives SPI write traffic into st7735_rx and checks every
// byte and pixel strobe against a transaction-level model of the panel.
module tb_st7735_rx;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 4;
`ifdef ST7735_RX_PIXEL_EN
  localparam bit PIX_EN = 1'b1;
`else
  localparam bit PIX_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cs;
  logic        mosi;
  logic        dc;
  logic        lcd_clk;
  logic        lcd_reset;
  logic        byte_valid;
  logic [7:0]  byte_q;
  logic        byte_is_data;
  logic        pix_valid;
  logic [7:0]  pix_x;
  logic [7:0]  pix_y;
  logic [15:0] pix_data;

  st7735_rx #(.SYNC_STAGES(SYNC_STAGES), .WIDTH(128), .HEIGHT(160)) dut (
    .SYSTEM_CLK  (clk),
    .RESET_N     (reset_n),
    .CS          (cs),
    .MOSI        (mosi),
    .DC          (dc),
    .LCD_CLK     (lcd_clk),
    .LCD_RESET   (lcd_reset),
    .BYTE_VALID  (byte_valid),
    .BYTE        (byte_q),
    .BYTE_IS_DATA(byte_is_data),
    .PIX_VALID   (pix_valid),
    .PIX_X       (pix_x),
    .PIX_Y       (pix_y),
    .PIX_DATA    (pix_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  b;
    logic        dc;
    logic        pix;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] d;
    int          due;
  } exp_t;

  typedef struct {
    int x;
    int y;
    int d;
  } pix_t;

  exp_t exp_q[$];
  pix_t model_log[$];

  int n_vec = 0;
  int n_mis = 0;
  int byte_seen = 0;
  int pix_seen = 0;
  logic [7:0] hold_byte = 8'h00;
  logic       hold_dc = 1'b0;

  // Panel model: last command, parameter count, window and cursor as integers.
  int m_cmd, m_pidx, m_xs, m_xe, m_ys, m_ye, m_cx, m_cy, m_hi;
  bit m_have_hi;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_defaults();
    m_cmd = 0; m_pidx = 0;
    m_xs = 0; m_xe = 127; m_ys = 0; m_ye = 159;
    m_cx = 0; m_cy = 0; m_hi = 0; m_have_hi = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input logic d, input int due);
    exp_t e;
    pix_t p;
    e.b = b; e.dc = d; e.pix = 1'b0; e.x = 0; e.y = 0; e.d = 0; e.due = due;
    if (!d) begin
      m_cmd = b; m_pidx = 0; m_have_hi = 0;
      if (b == 8'h2C) begin m_cx = m_xs; m_cy = m_ys; end
    end else if (m_cmd == 8'h2A || m_cmd == 8'h2B) begin
      if (m_pidx == 1) begin if (m_cmd == 8'h2A) m_xs = b; else m_ys = b; end
      if (m_pidx == 3) begin if (m_cmd == 8'h2A) m_xe = b; else m_ye = b; end
      m_pidx++;
    end else if (m_cmd == 8'h2C) begin
      if (!m_have_hi) begin
        m_hi = b; m_have_hi = 1;
      end else begin
        p.x = m_cx; p.y = m_cy; p.d = m_hi * 256 + b;
        model_log.push_back(p);
        e.pix = PIX_EN; e.x = 8'(p.x); e.y = 8'(p.y); e.d = 16'(p.d);
        m_have_hi = 0;
        if (m_cx == m_xe) begin
          m_cx = m_xs;
          m_cy = (m_cy == m_ye) ? m_ys : (m_cy + 1) % 256;
        end else begin
          m_cx = (m_cx + 1) % 256;
        end
      end
    end
    exp_q.push_back(e);
  endfunction

  // Compare process: every cycle, strobes are matched against the model queue
  // and the held byte outputs against the last accepted byte.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (byte_valid) begin
      byte_seen++;
      if (pix_valid) pix_seen++;
      if (exp_q.size() == 0) begin
        check_output("unexpected_byte_strobe", {31'b0, byte_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_output("byte", {24'b0, byte_q}, {24'b0, e.b});
        check_output("byte_is_data", {31'b0, byte_is_data}, {31'b0, e.dc});
        check_output("byte_latency", cyc, e.due);
        check_output("pix_valid", {31'b0, pix_valid}, {31'b0, e.pix});
        if (e.pix) begin
          check_output("pix_x", {24'b0, pix_x}, {24'b0, e.x});
          check_output("pix_y", {24'b0, pix_y}, {24'b0, e.y});
          check_output("pix_data", {16'b0, pix_data}, {16'b0, e.d});
        end
        hold_byte = e.b;
        hold_dc   = e.dc;
      end
    end else begin
      if (pix_valid) pix_seen++;
      check_output("idle_outputs", {22'b0, byte_q, byte_is_data, pix_valid},
                   {22'b0, hold_byte, hold_dc, 1'b0});
    end
  end

  // Shift the top n bits of v on the wire; a full byte is handed to the model.
  task automatic apply_stimulus(input logic [7:0] v, input logic d, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      mosi = v[i]; dc = d; lcd_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      lcd_clk = 1'b1;
      if (n == 8 && i == 0) model_byte(v, d, cyc + SYNC_STAGES + 2);
      repeat (HALF) @(negedge clk);
      lcd_clk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input logic d);
    apply_stimulus(v, d, 8);
  endtask

  task automatic cs_pulse();
    repeat (2) @(negedge clk);
    cs = 1'b1;
    repeat (6) @(negedge clk);
    cs = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_output(name, exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  int b0, p0, l0, r;
  logic [7:0] v;
  int ex[5] = '{2, 3, 2, 3, 2};
  int ey[5] = '{5, 5, 6, 6, 5};

  initial begin
    reset_n = 1'b0; cs = 1'b1; mosi = 1'b0; dc = 1'b0; lcd_clk = 1'b0; lcd_reset = 1'b1;
    model_defaults();
    repeat (3) @(negedge clk);

    check_output("rst_byte_valid", {31'b0, byte_valid}, 32'd0);
    check_output("rst_byte", {24'b0, byte_q}, 32'd0);
    check_output("rst_byte_is_data", {31'b0, byte_is_data}, 32'd0);
    check_output("rst_pix_valid", {31'b0, pix_valid}, 32'd0);
    check_output("rst_pix_x", {24'b0, pix_x}, 32'd0);
    check_output("rst_pix_y", {24'b0, pix_y}, 32'd0);
    check_output("rst_pix_data", {16'b0, pix_data}, 32'd0);

    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);

    // Single data byte.
    b0 = byte_seen;
    send_byte(8'hA5, 1'b1);
    wait_drain("drain_byte");
    check_output("byte_count", byte_seen - b0, 32'd1);
    check_output("byte_a5", {24'b0, byte_q}, 32'hA5);
    check_output("byte_a5_dc", {31'b0, byte_is_data}, 32'd1);

    // Aborted partial byte followed by a full command byte.
    apply_stimulus(8'hFF, 1'b1, 5);
    cs_pulse();
    b0 = byte_seen;
    send_byte(8'h3C, 1'b0);
    wait_drain("drain_abort");
    check_output("abort_count", byte_seen - b0, 32'd1);
    check_output("abort_byte", {24'b0, byte_q}, 32'h3C);
    check_output("abort_dc", {31'b0, byte_is_data}, 32'd0);

    // Half pixel discarded by an intervening command.
    p0 = pix_seen; l0 = model_log.size();
    send_byte(8'h2C, 1'b0); send_byte(8'hFF, 1'b1); send_byte(8'h00, 1'b0);
    send_byte(8'h2C, 1'b0); send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    wait_drain("drain_half");
    check_output("half_pix_count", pix_seen - p0, PIX_EN ? 32'd1 : 32'd0);
    check_output("half_model_count", model_log.size() - l0, 32'd1);
    check_output("half_model_x", model_log[l0].x, 32'd0);
    check_output("half_model_y", model_log[l0].y, 32'd0);
    check_output("half_model_d", model_log[l0].d, 32'h0001);

    // Window 2..3 x 5..6 and five pixels, the fifth wrapping the frame.
    b0 = byte_seen; p0 = pix_seen; l0 = model_log.size();
    send_byte(8'h2A, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h03, 1'b1);
    send_byte(8'h2B, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h05, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h06, 1'b1);
    send_byte(8'h2C, 1'b0);
    for (int k = 0; k < 5; k++) begin
      send_byte(8'h12, 1'b1);
      send_byte(8'(8'h34 + k), 1'b1);
    end
    wait_drain("drain_window");
    check_output("window_byte_count", byte_seen - b0, 32'd21);
    check_output("window_pix_count", pix_seen - p0, PIX_EN ? 32'd5 : 32'd0);
    check_output("window_model_count", model_log.size() - l0, 32'd5);
    for (int k = 0; k < 5; k++) begin
      check_output("window_model_x", model_log[l0 + k].x, ex[k]);
      check_output("window_model_y", model_log[l0 + k].y, ey[k]);
      check_output("window_model_d", model_log[l0 + k].d, 32'h1234 + k);
    end
`ifdef ST7735_RX_PIXEL_EN
    check_output("window_last_x", {24'b0, pix_x}, 32'd2);
    check_output("window_last_y", {24'b0, pix_y}, 32'd5);
    check_output("window_last_d", {16'b0, pix_data}, 32'h1238);
`endif

    // Panel reset pin after a CASET restores the default window.
    send_byte(8'h2A, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h03, 1'b1);
    wait_drain("drain_caset");
    lcd_reset = 1'b0;
    model_defaults();
    repeat (4) @(negedge clk);
    lcd_reset = 1'b1;
    repeat (6) @(negedge clk);
    check_output("lcdrst_byte_kept", {24'b0, byte_q}, 32'h03);
    p0 = pix_seen; l0 = model_log.size();
    send_byte(8'h2C, 1'b0); send_byte(8'hAB, 1'b1); send_byte(8'hCD, 1'b1);
    wait_drain("drain_lcdrst");
    check_output("lcdrst_pix_count", pix_seen - p0, PIX_EN ? 32'd1 : 32'd0);
    check_output("lcdrst_model_x", model_log[l0].x, 32'd0);
    check_output("lcdrst_model_y", model_log[l0].y, 32'd0);
    check_output("lcdrst_model_d", model_log[l0].d, 32'hABCD);

    // System reset in the middle of a byte.
    apply_stimulus(8'hF0, 1'b1, 4);
    reset_n = 1'b0;
    hold_byte = 8'h00; hold_dc = 1'b0;
    model_defaults();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    send_byte(8'h81, 1'b1);
    wait_drain("drain_sysrst");
    check_output("sysrst_byte", {24'b0, byte_q}, 32'h81);

    // Randomized traffic: commands, window parameters, pixels and aborts.
    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(0, 99);
      if (r < 8) begin
        apply_stimulus(8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(1, 7));
        cs_pulse();
      end else if (r < 25) begin
        case ($urandom_range(0, 4))
          0:       v = 8'h2A;
          1:       v = 8'h2B;
          2, 3:    v = 8'h2C;
          default: v = 8'($urandom);
        endcase
        send_byte(v, 1'b0);
      end else begin
        send_byte(8'($urandom), 1'b1);
      end
    end
    wait_drain("drain_random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
